// File: rtl/ppi_cpu_master.sv
// CPU-side PPI bus initiator: turns single-beat host read/write or BSR requests
// into timed cs_n / rd_n / wr_n / A / D bus cycles with configurable phase lengths.
module ppi_cpu_master #(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       bsr_valid,
  output logic       bsr_ready,
  input  logic [2:0] bsr_bit,
  input  logic       bsr_set,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [1:0] a,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  // Handshake: a request or BSR command transfers on a rising edge where its
  // valid and ready are both high; the host holds valid (and payload) until then.
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  localparam logic [3:0] SETUP_LD    = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD   = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD     = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOVERY_LD = 4'((RECOVERY_CYC > 0) ? RECOVERY_CYC - 1 : 0);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic       op_write, op_write_d;
  logic [7:0] rdata, rdata_d;
  logic       cs_n_d, rd_n_d, wr_n_d, d_oe_d, rsp_valid_d, req_ready_d;
  logic [1:0] a_d;
  logic [7:0] d_out_d, rsp_rdata_d;
  logic       accept_req, accept_bsr;

  // req has priority, so BSR is only offered while no request is pending.
  assign bsr_ready  = req_ready & ~req_valid;
  assign accept_req = req_valid & req_ready;
  assign accept_bsr = bsr_valid & bsr_ready;

  always_comb begin
    state_d     = state;
    cnt_d       = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    op_write_d  = op_write;
    rdata_d     = rdata;
    cs_n_d      = cs_n;
    rd_n_d      = rd_n;
    wr_n_d      = wr_n;
    a_d         = a;
    d_out_d     = d_out;
    d_oe_d      = d_oe;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    req_ready_d = 1'b0;
    case (state)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept_req) begin
          state_d     = SETUP;
          cnt_d       = SETUP_LD;
          op_write_d  = req_write;
          cs_n_d      = 1'b0;
          a_d         = req_addr;
          d_out_d     = req_write ? req_wdata : 8'h00;
          d_oe_d      = req_write;
          req_ready_d = 1'b0;
        end else if (accept_bsr) begin
          // BSR is a control-register write with bit 7 clear.
          state_d     = SETUP;
          cnt_d       = SETUP_LD;
          op_write_d  = 1'b1;
          cs_n_d      = 1'b0;
          a_d         = 2'b11;
          d_out_d     = {4'b0000, bsr_bit, bsr_set};
          d_oe_d      = 1'b1;
          req_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          rd_n_d  = op_write;
          wr_n_d  = ~op_write;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          if (!op_write) rdata_d = d_in;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          cs_n_d      = 1'b1;
          d_oe_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = op_write ? 8'h00 : rdata;
          if (RECOVERY_CYC == 0) begin
            state_d     = IDLE;
            cnt_d       = 4'd0;
            req_ready_d = 1'b1;
          end else begin
            state_d = RECOVER;
            cnt_d   = RECOVERY_LD;
          end
        end
      end
      RECOVER: begin
        if (cnt == 4'd0) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      rdata     <= 8'h00;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      a         <= 2'b00;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      req_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op_write  <= op_write_d;
      rdata     <= rdata_d;
      cs_n      <= cs_n_d;
      rd_n      <= rd_n_d;
      wr_n      <= wr_n_d;
      a         <= a_d;
      d_out     <= d_out_d;
      d_oe      <= d_oe_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      req_ready <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_ppi_cpu_master.sv
// Bench for ppi_cpu_master: default timing (u0) and a stretched, no-recovery
// configuration (u1), with a response scoreboard and a bus-beat monitor.
module tb_ppi_cpu_master;

  logic clk;
  logic rst;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [1:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       bsr_valid [2];
  logic       bsr_ready [2];
  logic [2:0] bsr_bit   [2];
  logic       bsr_set   [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       cs_n      [2];
  logic       rd_n      [2];
  logic       wr_n      [2];
  logic [1:0] a         [2];
  logic [7:0] d_out     [2];
  logic       d_oe      [2];
  logic [7:0] d_in      [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  exp_q[$];
  int          exp_t_q[$];
  logic [11:0] exp_bus_q[$];
  logic [7:0]  rd_q[$];

  ppi_cpu_master u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .bsr_valid(bsr_valid[0]), .bsr_ready(bsr_ready[0]), .bsr_bit(bsr_bit[0]), .bsr_set(bsr_set[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]), .a(a[0]),
    .d_out(d_out[0]), .d_oe(d_oe[0]), .d_in(d_in[0])
  );

  ppi_cpu_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2), .RECOVERY_CYC(0)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .bsr_valid(bsr_valid[1]), .bsr_ready(bsr_ready[1]), .bsr_bit(bsr_bit[1]), .bsr_set(bsr_set[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]), .a(a[1]),
    .d_out(d_out[1]), .d_oe(d_oe[1]), .d_in(d_in[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int stb_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction
  function automatic int cs_of(input int i);
    return (i == 0) ? 4 : 9;
  endfunction
  function automatic int lat_of(input int i);
    return (i == 0) ? 5 : 10;
  endfunction

  // ---------------- monitor ----------------
  int          st_w [2];
  int          cs_w [2];
  logic [11:0] beat0 [2];
  bit          st_ok [2];
  bit          st_rd [2];
  logic [11:0] cur;
  logic [11:0] eb;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        st_w[i] = 0;
        cs_w[i] = 0;
      end else begin
        check($sformatf("u%0d_inv_rdwr", i), 32'(!rd_n[i] && !wr_n[i]), 0);
        check($sformatf("u%0d_inv_cs", i), 32'((!rd_n[i] || !wr_n[i]) && cs_n[i]), 0);
        check($sformatf("u%0d_inv_oe", i), 32'(d_oe[i] && !rd_n[i]), 0);
        cur = {d_oe[i], ~wr_n[i], a[i], (!wr_n[i]) ? d_out[i] : 8'h00};
        if (!rd_n[i] || !wr_n[i]) begin
          if (st_w[i] == 0) begin
            beat0[i] = cur;
            st_ok[i] = 1'b1;
            st_rd[i] = !rd_n[i];
          end else if (cur !== beat0[i]) begin
            st_ok[i] = 1'b0;
          end
          st_w[i]++;
        end else if (st_w[i] > 0) begin
          if (st_rd[i] && rd_q.size() > 0) void'(rd_q.pop_front());
          if (exp_bus_q.size() == 0) begin
            check($sformatf("u%0d_bus_unexpected", i), 1, 0);
          end else begin
            eb = exp_bus_q.pop_front();
            check($sformatf("u%0d_bus_beat", i), 32'(beat0[i]), 32'(eb));
            check($sformatf("u%0d_strobe_width", i), st_w[i], stb_of(i));
            check($sformatf("u%0d_bus_stable", i), 32'(st_ok[i]), 1);
          end
          st_w[i] = 0;
        end
        if (!cs_n[i]) cs_w[i]++;
        else if (cs_w[i] > 0) begin
          check($sformatf("u%0d_cs_width", i), cs_w[i], cs_of(i));
          cs_w[i] = 0;
        end
      end
      if (rsp_valid[i]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("u%0d_rsp_unexpected", i), 1, 0);
        end else begin
          check($sformatf("u%0d_rsp_rdata", i), 32'(rsp_rdata[i]), 32'(exp_q.pop_front()));
          check($sformatf("u%0d_rsp_time", i), cyc, exp_t_q.pop_front());
        end
      end
      // PPI model: read data is only presented while rd_n is low.
      d_in[i] = (!rd_n[i] && rd_q.size() > 0) ? rd_q[0] : 8'hEE;
    end
  end

  // ---------------- drivers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_op(input int i, input bit is_bsr, input bit wr, input logic [1:0] ad,
                       input logic [7:0] data, input bit push, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    if (is_bsr) begin
      bsr_valid[i] = 1'b1;
      bsr_bit[i]   = data[3:1];
      bsr_set[i]   = data[0];
    end else begin
      req_valid[i] = 1'b1;
      req_write[i] = wr;
      req_addr[i]  = ad;
      req_wdata[i] = wr ? data : 8'h00;
    end
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (is_bsr ? bsr_ready[i] : req_ready[i]) got = 1'b1;
    end
    if (!got) begin
      check($sformatf("u%0d_accept_timeout", i), 0, 1);
    end else begin
      acc = cyc;
      if (push) begin
        if (is_bsr) begin
          exp_bus_q.push_back({1'b1, 1'b1, 2'b11, 4'b0000, data[3:0]});
          exp_q.push_back(8'h00);
        end else begin
          exp_bus_q.push_back({wr, wr, ad, wr ? data : 8'h00});
          exp_q.push_back(wr ? 8'h00 : data);
          if (!wr) rd_q.push_back(data);
        end
        exp_t_q.push_back(acc + lat_of(i));
      end
      @(posedge clk);
    end
    #1;
    if (is_bsr) bsr_valid[i] = 1'b0;
    else req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    check("drain_rsp_left", exp_q.size(), 0);
    check("drain_bus_left", exp_bus_q.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int acc1, acc2;
  int kind;
  logic [1:0] r_ad;
  logic [7:0] r_d;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 2'b00; req_wdata[i] = 8'h00;
      bsr_valid[i] = 1'b0; bsr_bit[i] = 3'd0; bsr_set[i] = 1'b0; d_in[i] = 8'hEE;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_rst_cs_n", i), 32'(cs_n[i]), 1);
      check($sformatf("u%0d_rst_rd_n", i), 32'(rd_n[i]), 1);
      check($sformatf("u%0d_rst_wr_n", i), 32'(wr_n[i]), 1);
      check($sformatf("u%0d_rst_d_oe", i), 32'(d_oe[i]), 0);
      check($sformatf("u%0d_rst_rsp_valid", i), 32'(rsp_valid[i]), 0);
      check($sformatf("u%0d_rst_req_ready", i), 32'(req_ready[i]), 0);
      check($sformatf("u%0d_rst_bsr_ready", i), 32'(bsr_ready[i]), 0);
      check($sformatf("u%0d_rst_a", i), 32'(a[i]), 0);
      check($sformatf("u%0d_rst_d_out", i), 32'(d_out[i]), 0);
      check($sformatf("u%0d_rst_rsp_rdata", i), 32'(rsp_rdata[i]), 0);
    end
    @(negedge clk);
    check("u0_idle_req_ready", 32'(req_ready[0]), 1);
    check("u0_idle_bsr_ready", 32'(bsr_ready[0]), 1);
    check("u0_idle_cs_n", 32'(cs_n[0]), 1);
    @(posedge clk);
    #1;

    // Control-register write, then port A read.
    do_op(0, 1'b0, 1'b1, 2'b11, 8'h90, 1'b1, acc1);
    wait_drain();
    do_op(0, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b1, acc1);
    wait_drain();

    // Simultaneous request and BSR: the read goes first, BSR follows.
    bsr_valid[0] = 1'b1; bsr_bit[0] = 3'd5; bsr_set[0] = 1'b1;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 2'b01;
    #1;
    check("u0_bsr_blocked", 32'(bsr_ready[0]), 0);
    do_op(0, 1'b0, 1'b0, 2'b01, 8'h3C, 1'b1, acc1);
    do_op(0, 1'b1, 1'b1, 2'b11, 8'h0B, 1'b1, acc2);
    check("u0_bsr_after_req_gap", acc2 - acc1, 6);
    wait_drain();

    // Back-to-back writes.
    do_op(0, 1'b0, 1'b1, 2'b00, 8'h11, 1'b1, acc1);
    do_op(0, 1'b0, 1'b1, 2'b01, 8'h22, 1'b1, acc2);
    check("u0_b2b_gap", acc2 - acc1, 6);
    wait_drain();

    // Reset during the strobe aborts the cycle with no response.
    do_op(0, 1'b0, 1'b1, 2'b10, 8'h55, 1'b0, acc1);
    for (int k = 0; k < 20 && wr_n[0]; k++) @(negedge clk);
    check("u0_abort_strobe_seen", 32'(wr_n[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    check("u0_abort_cs_n", 32'(cs_n[0]), 1);
    check("u0_abort_wr_n", 32'(wr_n[0]), 1);
    check("u0_abort_rd_n", 32'(rd_n[0]), 1);
    check("u0_abort_d_oe", 32'(d_oe[0]), 0);
    check("u0_abort_rsp_valid", 32'(rsp_valid[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    do_op(0, 1'b0, 1'b0, 2'b10, 8'h5A, 1'b1, acc1);
    wait_drain();

    // Random mix of reads, writes and BSR commands issued back to back.
    for (int n = 0; n < 8; n++) begin
      kind = $urandom_range(0, 2);
      r_ad = 2'($urandom_range(0, 3));
      r_d  = 8'($urandom_range(0, 255));
      if (kind == 2) do_op(0, 1'b1, 1'b1, 2'b11, {4'b0000, r_d[3:0]}, 1'b1, acc1);
      else do_op(0, 1'b0, kind == 1, r_ad, r_d, 1'b1, acc1);
    end
    wait_drain();

    // Stretched timing, no recovery.
    do_op(1, 1'b0, 1'b1, 2'b10, 8'hC3, 1'b1, acc1);
    do_op(1, 1'b0, 1'b0, 2'b11, 8'h7E, 1'b1, acc2);
    check("u1_b2b_gap", acc2 - acc1, 10);
    do_op(1, 1'b1, 1'b1, 2'b11, 8'h06, 1'b1, acc1);
    check("u1_bsr_gap", acc1 - acc2, 10);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ppi_cpu_master.md
Name: ppi_cpu_master

Overview:
- CPU-side bus initiator for the PPI. Turns single-beat requests from a host (plain read/write, or BSR bit set/reset command) into timed PPI bus cycles: cs_n, rd_n, wr_n, A1:A0, D7:D0.
- It is the counterpart that drives the control-word decoders and port logic, which act as the responder.
- Sits between the host core and the PPI top level.

Parameters:
- SETUP_CYC, 1, cycles with address/cs_n (and write data) valid before the strobe asserts; legal range 1..15
- STROBE_CYC, 2, cycles rd_n/wr_n held low; legal range 1..15
- HOLD_CYC, 1, cycles address/data held after the strobe deasserts; legal range 1..15
- RECOVERY_CYC, 1, idle cycles (cs_n high) before the next cycle may start; 0..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  host request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  2  A1:A0 (00 A, 01 B, 10 C, 11 control)
- req_wdata  in  8  write data
- bsr_valid  in  1  BSR command present
- bsr_ready  out  1  BSR command accepted when bsr_valid & bsr_ready
- bsr_bit  in  3  port C bit number
- bsr_set  in  1  1 = set, 0 = reset
- rsp_valid  out  1  one-cycle pulse: read data valid, or write/BSR complete
- rsp_rdata  out  8  read data; 0 after writes
- cs_n  out  1  chip select, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- a  out  2  PPI address
- d_out  out  8  data driven to PPI
- d_oe  out  1  1 = d_out drives the data bus
- d_in  in  8  data from PPI

Behaviour:
- Reset (rst high at a clock edge): state IDLE.
  - cs_n, rd_n and wr_n are 1.
  - a, d_out, rsp_rdata and all counters are 0.
  - d_oe, rsp_valid, req_ready and bsr_ready are 0 in the cycle after reset.
  - rst mid-cycle aborts the cycle. Strobes are high on the next edge and no rsp_valid is issued for the aborted transaction.
- All outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER.
- IDLE:
  - req_ready = 1.
  - bsr_ready = ~req_valid. When both are valid, req wins.
  - On acceptance, latch the operation and go to SETUP.
  - Next edge: cs_n = 0, a = latched address, and for writes d_out/d_oe = 1.
- BSR encoding: write to a = 11 with d_out = {1'b0, 3'b000, bsr_bit, bsr_set}. Bit 7 is 0, which selects BSR.
- SETUP: lasts SETUP_CYC cycles, then STROBE.
- STROBE:
  - Lasts STROBE_CYC cycles with rd_n = 0 (read) or wr_n = 0 (write).
  - Read data is captured from d_in on the last STROBE cycle.
  - Exit to HOLD: strobe goes to 1; cs_n, a and d_out are unchanged.
- HOLD:
  - Lasts HOLD_CYC cycles.
  - On exit: cs_n = 1, d_oe = 0, and rsp_valid pulses for exactly one cycle.
  - rsp_rdata = captured byte for reads, 0 for writes/BSR.
  - Next state is RECOVER, or IDLE if RECOVERY_CYC = 0.
- RECOVER: lasts RECOVERY_CYC cycles, then IDLE. req_ready and bsr_ready are 0 in every state except IDLE.
- rd_n and wr_n are never both 0.
- Strobes are low only while cs_n = 0.
- d_oe is never 1 during a read.
- Throughput with defaults: cycle = 1 accept + 1 setup + 2 strobe + 1 hold + 1 recovery.
  - Back-to-back requests are accepted every 6 cycles.
  - rsp_valid arrives 5 cycles after acceptance.
- Inputs arriving while busy are ignored, not queued. The host must hold valid until ready.
- Counters are 4 bits, reload on each state entry, and do not wrap.

Test Plan:
- Reset with all inputs idle → cs_n = rd_n = wr_n = 1, d_oe = 0, req_ready = 1 the cycle after rst drops.
- Write req addr = 11, wdata = 8'h90 → cs_n low 4 cycles, wr_n low exactly 2 cycles with a = 11 and d_out = 90 stable throughout, rsp_valid one pulse 5 cycles after acceptance.
- Read addr = 00 with d_in = 8'hA5 during strobe → rd_n low 2 cycles, d_oe = 0 throughout, rsp_rdata = A5 with rsp_valid.
- BSR bit = 5, set = 1 together with req_valid (read addr = 01) → read executes first. Next accepted cycle writes a = 11, d_out = 8'h0B.
- rst asserted during STROBE → next edge strobes and cs_n high, no rsp_valid. Next request completes normally.
- Parameters SETUP = 3, STROBE = 4, HOLD = 2, RECOVERY = 0 → strobe width 4 and back-to-back acceptance every 10 cycles. Check that the strobe and cs_n invariants hold.
